// File: rtl/serial_mult_arbiter.sv
// serial_mult_arbiter: round-robin sharing of one serial multiplier among N_REQ requesters
//   requester side: req, a_in, b_in in; gnt (operands sampled), rsp_valid/rsp_data/rsp_err out; busy out
//   multiplier side: mul_start, mul_a, mul_b out; mul_p, mul_done in
module serial_mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 2*WIDTH+4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_p,
  input  logic                     mul_done
);
  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT+1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t               state_q;
  logic [IW-1:0]        rr_q, sel_q, pick_d, off;
  logic [IW:0]          sum;
  logic [WW-1:0]        wd_q;
  logic [N_REQ-1:0]     rsp_valid_q;
  logic [2*WIDTH-1:0]   rsp_data_q;
  logic                 rsp_err_q, mul_start_q;
  logic [WIDTH-1:0]     mul_a_q, mul_b_q;
  logic [2*N_REQ-1:0]   rot;
  // rot[k] is req[(rr_q+k) mod N_REQ]; the lowest set k is the next winner
  assign rot = {req, req} >> rr_q;
  always_comb begin
    off = '0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (rot[k]) off = IW'(k);
    sum = {1'b0, rr_q} + {1'b0, off};
    pick_d = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : IW'(sum);
  end
  // gnt is the same-cycle acknowledgement that the operands are being sampled
  assign gnt       = (state_q == IDLE && !rst && |req) ? {{(N_REQ-1){1'b0}}, 1'b1} << pick_d : '0;
  assign busy      = state_q != IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      sel_q       <= '0;
      wd_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: if (|req) begin
          sel_q   <= pick_d;
          mul_a_q <= a_in[pick_d*WIDTH +: WIDTH];
          mul_b_q <= b_in[pick_d*WIDTH +: WIDTH];
          state_q <= LOAD;
        end
        LOAD: begin
          wd_q        <= '0;
          mul_start_q <= 1'b1;
          state_q     <= RUN;
        end
        RUN: begin
          wd_q <= wd_q + 1'b1;
          // wd_q==0 is the first RUN cycle, where Done may still be left over from the previous job
          if ((mul_done && wd_q != '0) || wd_q == WW'(TIMEOUT-1)) begin
            rsp_data_q  <= (mul_done && wd_q != '0) ? mul_p : '0;
            rsp_err_q   <= !(mul_done && wd_q != '0);
            rsp_valid_q <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_q;
            mul_start_q <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          rr_q    <= (sel_q == IW'(N_REQ-1)) ? '0 : sel_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_mult_arbiter.sv
// tb_serial_mult_arbiter: job-level model check of serial_mult_arbiter with directed vectors
module tb_serial_mult_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 2*W+4;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0, b_in = '0;
  logic [N-1:0]   gnt, rsp_valid;
  logic [2*W-1:0] rsp_data, mul_p;
  logic           rsp_err, busy, mul_start, mul_done;
  logic [W-1:0]   mul_a, mul_b;
  int             n_chk = 0, n_fail = 0;
  int             d_lat = 4;
  bit             force0 = 1'b0;
  int             cnt;
  logic [N-1:0]   gnt_seen = '0, hold = '0;
  bit             m_act = 1'b0, m_err = 1'b0;
  int             m_t = 0, m_len = 0, m_own = 0, m_ptr = 0;
  logic [2*W-1:0] m_res = '0, m_data = '0;
  logic [W-1:0]   m_ma = '0, m_mb = '0;

  serial_mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // serial multiplier stand-in: Done is left high while idle (stale) and garbage P goes with it
  always @(posedge clk or posedge rst)
    if (rst) cnt <= 0;
    else if (!mul_start) cnt <= 0;
    else cnt <= cnt + 1;
  assign mul_done = force0 ? 1'b0 : (cnt == 0 ? 1'b1 : cnt >= d_lat);
  assign mul_p    = (cnt != 0 && cnt >= d_lat) ? {4'b0, mul_a} * {4'b0, mul_b} : 8'hA5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p+k)%N]) return (p+k)%N;
    return -1;
  endfunction

  // requesters drop req once granted unless told to keep requesting
  always begin
    @(posedge clk);
    #1;
    req = req & ~(gnt_seen & ~hold);
    gnt_seen = '0;
  end

  always @(negedge clk) begin
    int p, n;
    logic [N-1:0] eg, ev;
    if (rst) begin
      chk("rst_gnt", gnt, 0); chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0); chk("rst_mul_start", mul_start, 0);
      chk("rst_rsp_data", rsp_data, 0); chk("rst_rsp_err", rsp_err, 0);
      chk("rst_mul_a", mul_a, 0); chk("rst_mul_b", mul_b, 0);
      m_act = 1'b0; m_ptr = 0; m_data = '0; m_ma = '0; m_mb = '0;
    end else begin
      p = m_act ? -1 : pick(req, m_ptr);
      eg = '0; if (p >= 0) eg[p] = 1'b1;
      ev = '0; if (m_act && m_t == m_len+2) ev[m_own] = 1'b1;
      chk("gnt", gnt, eg);
      chk("busy", busy, m_act);
      chk("mul_start", mul_start, m_act && m_t >= 2 && m_t <= m_len+1);
      chk("rsp_valid", rsp_valid, ev);
      if (ev != 0) chk("rsp_err", rsp_err, m_err);
      chk("rsp_data", rsp_data, m_data);
      chk("mul_a", mul_a, m_ma);
      chk("mul_b", mul_b, m_mb);
      gnt_seen = gnt_seen | gnt;
      if (p >= 0) begin
        m_act = 1'b1; m_t = 1; m_own = p;
        m_ma = a_in[p*W +: W]; m_mb = b_in[p*W +: W];
        m_res = 8'(m_ma) * 8'(m_mb);
        n = force0 ? TO+1 : d_lat+1;
        m_err = n > TO;
        m_len = m_err ? TO : n;
      end else if (m_act) begin
        if (m_t == m_len+1) m_data = m_err ? '0 : m_res;
        if (m_t == m_len+2) begin m_act = 1'b0; m_ptr = (m_own+1)%N; end
        else m_t++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(input int idx, input int data, input bit err, input string nm);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) break;
    end
    if (k == 60) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no rsp_valid within 60 cycles, required requester %0d", nm, idx);
    end else begin
      chk({nm, "_valid"}, rsp_valid, 1 << idx);
      chk({nm, "_data"}, rsp_data, data);
      chk({nm, "_err"}, rsp_err, err);
    end
  endtask

  task automatic wait_gnt(input int idx, input string nm);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (gnt[idx]) break;
    end
    if (k == 60) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no gnt within 60 cycles, required requester %0d", nm, idx);
    end else chk(nm, gnt, 1 << idx);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick(); a_in[3:0] = 4'd10; b_in[3:0] = 4'd13; req = 4'b0001;
    wait_rsp(0, 130, 0, "t1");
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin a_in[i*W +: W] = W'(i+1); b_in[i*W +: W] = 4'd3; end
    req = 4'b1111;
    wait_rsp(0, 3, 0, "t2_r0"); wait_rsp(1, 6, 0, "t2_r1");
    wait_rsp(2, 9, 0, "t2_r2"); wait_rsp(3, 12, 0, "t2_r3");
    tick(); hold = 4'b0100; a_in[11:8] = 4'd5; b_in[11:8] = 4'd7; req[2] = 1'b1;
    wait_gnt(2, "t3_gnt2");
    tick(); a_in[7:4] = 4'd9; b_in[7:4] = 4'd9; req[1] = 1'b1;
    wait_rsp(2, 35, 0, "t3_first2");
    wait_rsp(1, 81, 0, "t3_then1");
    hold = '0;
    wait_rsp(2, 35, 0, "t3_again2");
    tick(); a_in[3:0] = 4'd15; b_in[3:0] = 4'd15; req = 4'b0001;
    wait_gnt(0, "t4_gnt0");
    tick(); a_in[3:0] = 4'd0; b_in[3:0] = 4'd1;
    wait_rsp(0, 225, 0, "t4");
    force0 = 1'b1;
    tick(); a_in[3:0] = 4'd3; b_in[3:0] = 4'd5; req = 4'b0001;
    wait_rsp(0, 0, 1, "t5_timeout");
    force0 = 1'b0;
    tick(); a_in[7:4] = 4'd2; b_in[7:4] = 4'd6; req = 4'b0010;
    wait_rsp(1, 12, 0, "t5_recover");
    d_lat = TO-1;
    tick(); a_in[11:8] = 4'd7; b_in[11:8] = 4'd3; req = 4'b0100;
    wait_rsp(2, 21, 0, "t5_done_at_limit");
    d_lat = TO;
    tick(); a_in[15:12] = 4'd4; b_in[15:12] = 4'd4; req = 4'b1000;
    wait_rsp(3, 0, 1, "t5_done_too_late");
    d_lat = 4;
    tick(); a_in[15:12] = 4'd6; b_in[15:12] = 4'd6; req = 4'b1000;
    wait_gnt(3, "t6_gnt3");
    tick(); tick();
    chk("t6_running", mul_start, 1);
    rst = 1'b1;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_mul_start", mul_start, 0);
    chk("t6_async_mul_a", mul_a, 0);
    tick(); rst = 1'b0;
    repeat (20) tick();
    a_in[15:12] = 4'd6; b_in[15:12] = 4'd7; req = 4'b1000;
    wait_rsp(3, 42, 0, "t6_fresh");
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
